// File: rtl/boreal_ai_mailbox_writer.sv
// AI-side mailbox writer: streams 16-word result frames into alternating mailbox
// slots over the MMIO bus. It polls the slot's valid flag before writing so that
// a frame the Decision-VM has not yet acknowledged is never overwritten.
module boreal_ai_mailbox_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data,
  input  logic        res_last,
  output logic        m_sel,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        cur_slot,
  output logic        frame_done,
  output logic        frame_err,
  output logic        err_timeout
);

  localparam logic [7:0]  GapLast = 8'(POLL_GAP - 1);
  localparam logic [15:0] ToLast  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StPoll, StWait, StData, StPad, StDrain, StCommit
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_sel, w_sel_d;
  logic        r_wr, w_wr_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [3:0]  r_idx, w_idx_d;
  logic        r_slot, w_slot_d;
  logic        r_err, w_err_d;
  logic        r_last, w_last_d;
  logic [7:0]  r_gap, w_gap_d;
  logic [15:0] r_to, w_to_d;
  logic        r_to_pulse, w_to_pulse_d;
  logic        w_done, w_ferr;
  logic        w_ack, w_abort;
  logic [31:0] w_flag_addr, w_data_addr;

  assign w_ack       = r_sel & m_ack;
  assign w_abort     = r_sel & ~m_ack & (r_to == ToLast);
  assign w_flag_addr = BASE_ADDR + {29'd0, r_slot, 2'b00};
  assign w_data_addr = BASE_ADDR + 32'h40 + {25'd0, r_slot, 6'd0} + {26'd0, r_idx, 2'b00};

  // State and bus registers; bus fields only change when a new access is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sel      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_idx      <= 4'h0;
      r_slot     <= 1'b0;
      r_err      <= 1'b0;
      r_last     <= 1'b0;
      r_gap      <= 8'h0;
      r_to       <= 16'h0;
      r_to_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_sel      <= w_sel_d;
      r_wr       <= w_wr_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_idx      <= w_idx_d;
      r_slot     <= w_slot_d;
      r_err      <= w_err_d;
      r_last     <= w_last_d;
      r_gap      <= w_gap_d;
      r_to       <= w_to_d;
      r_to_pulse <= w_to_pulse_d;
    end
  end

  // Next-state, bus issue and commit pulses.
  always_comb begin
    w_state_d    = r_state;
    w_sel_d      = r_sel;
    w_wr_d       = r_wr;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_idx_d      = r_idx;
    w_slot_d     = r_slot;
    w_err_d      = r_err;
    w_last_d     = r_last;
    w_gap_d      = r_gap;
    w_to_d       = (r_sel && !m_ack) ? r_to + 16'd1 : 16'd0;
    w_to_pulse_d = 1'b0;
    w_done       = 1'b0;
    w_ferr       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (res_valid) begin
          w_state_d = StPoll;
          w_sel_d   = 1'b1;
          w_wr_d    = 1'b0;
          w_addr_d  = w_flag_addr;
        end
      end
      StPoll: begin
        if (w_ack) begin
          w_sel_d = 1'b0;
          if (m_rdata[0]) begin
            w_state_d = StWait;
            w_gap_d   = 8'h0;
          end else begin
            w_state_d = StData;
            w_idx_d   = 4'h0;
          end
        end
      end
      StWait: begin
        if (r_gap == GapLast) begin
          w_gap_d   = 8'h0;
          w_state_d = StPoll;
          w_sel_d   = 1'b1;
          w_wr_d    = 1'b0;
          w_addr_d  = w_flag_addr;
        end else begin
          w_gap_d = r_gap + 8'd1;
        end
      end
      StData: begin
        if (!r_sel) begin
          if (res_valid) begin
            w_sel_d   = 1'b1;
            w_wr_d    = 1'b1;
            w_addr_d  = w_data_addr;
            w_wdata_d = res_data;
            w_last_d  = res_last;
          end
        end else if (w_ack) begin
          w_sel_d = 1'b0;
          if (r_idx == 4'hF) begin
            if (r_last) begin
              w_state_d = StCommit;
            end else begin
              w_err_d   = 1'b1;
              w_state_d = StDrain;
            end
          end else begin
            w_idx_d = r_idx + 4'd1;
            if (r_last) begin
              w_err_d   = 1'b1;
              w_state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        if (!r_sel) begin
          w_sel_d   = 1'b1;
          w_wr_d    = 1'b1;
          w_addr_d  = w_data_addr;
          w_wdata_d = 32'h0;
        end else if (w_ack) begin
          w_sel_d = 1'b0;
          if (r_idx == 4'hF) w_state_d = StCommit;
          else               w_idx_d   = r_idx + 4'd1;
        end
      end
      StDrain: begin
        if (res_valid && res_last) w_state_d = StCommit;
      end
      StCommit: begin
        if (!r_sel) begin
          w_sel_d   = 1'b1;
          w_wr_d    = 1'b1;
          w_addr_d  = w_flag_addr;
          w_wdata_d = 32'h1;
        end else if (w_ack) begin
          w_sel_d   = 1'b0;
          w_done    = 1'b1;
          w_ferr    = r_err;
          w_err_d   = 1'b0;
          w_slot_d  = ~r_slot;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A stuck slave abandons the frame: no commit, slot kept for the retry.
    if (w_abort) begin
      w_sel_d      = 1'b0;
      w_state_d    = StIdle;
      w_err_d      = 1'b0;
      w_to_d       = 16'h0;
      w_to_pulse_d = 1'b1;
    end
  end

  assign res_ready   = ((r_state == StData) && !r_sel) || (r_state == StDrain);
  assign m_sel       = r_sel;
  assign m_wr        = r_wr;
  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign busy        = (r_state != StIdle);
  assign cur_slot    = r_slot;
  assign frame_done  = w_done;
  assign frame_err   = w_ferr;
  assign err_timeout = r_to_pulse;

endmodule

// File: tb/tb_boreal_ai_mailbox_writer.sv
// Bench for the mailbox writer: a mailbox slave model, a frame-level expectation
// queue and a per-cycle compare process, plus directed literal checks per scenario.
module tb_boreal_ai_mailbox_writer;

  localparam int unsigned TbGap = 4;
  localparam int unsigned TbTo  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, res_ready, res_last;
  logic [31:0] res_data;
  logic        m_sel, m_wr, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, cur_slot, frame_done, frame_err, err_timeout;

  boreal_ai_mailbox_writer #(
    .BASE_ADDR  (32'h0),
    .POLL_GAP   (TbGap),
    .ACK_TIMEOUT(TbTo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .m_sel      (m_sel),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ack      (m_ack),
    .busy       (busy),
    .cur_slot   (cur_slot),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mailbox slave model: two valid flags, two 16-word data slots.
  logic [31:0] mb_flag [2]     = '{32'h0, 32'h0};
  logic [31:0] mb_data [2][16] = '{default: 32'h0};
  logic        vm_clr = 1'b0;
  logic        vm_clr_slot = 1'b0;
  logic        hang_wr = 1'b0;
  int          lat = 0;
  int          lat_cnt = 0;

  assign m_ack   = m_sel && !(hang_wr && m_wr) && (lat_cnt >= lat);
  assign m_rdata = (m_addr < 32'h8) ? mb_flag[m_addr[2]] : 32'h0;

  // Slave storage update and latency counter.
  always @(posedge clk) begin
    if (!m_sel || m_ack) lat_cnt <= 0;
    else                 lat_cnt <= lat_cnt + 1;
    if (vm_clr) mb_flag[vm_clr_slot] <= 32'h0;
    if (m_sel && m_ack && m_wr) begin
      if (m_addr < 32'h8) mb_flag[m_addr[2]] <= m_wdata;
      else if (m_addr >= 32'h40 && m_addr < 32'hC0) mb_data[~m_addr[6]][m_addr[5:2]] <= m_wdata;
    end
  end

  // Frame-level model: the ordered writes a frame must produce.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        commit;
    logic        err;
  } wr_t;
  wr_t  exp_q[$];
  logic exp_slot = 1'b0;

  int n_done = 0, n_err = 0, n_writes = 0, n_busy_polls = 0, n_timeouts = 0;

  task automatic push_frame(input int n, input logic [31:0] base);
    wr_t w;
    for (int i = 0; i < 16; i++) begin
      w.addr   = 32'h40 + (exp_slot ? 32'h40 : 32'h0) + 32'(4 * i);
      w.data   = (i < n) ? base + 32'(i) : 32'h0;
      w.commit = 1'b0;
      w.err    = 1'b0;
      exp_q.push_back(w);
    end
    w.addr   = exp_slot ? 32'h4 : 32'h0;
    w.data   = 32'h1;
    w.commit = 1'b1;
    w.err    = (n != 16);
    exp_q.push_back(w);
  endtask

  // Per-cycle compare against the model.
  int          cyc = 0, last_poll = 0, run = 0;
  logic        last_busy = 1'b0, p_hold = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
  always @(negedge clk) begin
    wr_t  e;
    logic e_done, e_err, e_to;
    cyc++;
    if (rst) begin
      exp_slot  = 1'b0;
      run       = 0;
      last_busy = 1'b0;
      p_hold    = 1'b0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      e_to   = (run == int'(TbTo));
      if (p_hold && !e_to) begin
        chk("bus_hold_sel", 32'({m_sel, m_wr}), 32'({1'b1, p_wr}));
        chk("bus_hold_addr", m_addr, p_addr);
        chk("bus_hold_wdata", m_wdata, p_wdata);
      end
      if (m_sel && m_ack && m_wr) begin
        n_writes++;
        if (m_addr >= 32'h40) chk("overwrite_guard", 32'(mb_flag[~m_addr[6]][0]), 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", m_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", m_addr, e.addr);
          chk("wr_data", m_wdata, e.data);
          e_done = e.commit;
          e_err  = e.err;
        end
      end
      if (m_sel && m_ack && !m_wr) begin
        chk("poll_addr", m_addr, exp_slot ? 32'h4 : 32'h0);
        if (last_busy && lat == 0) chk("poll_gap", 32'(cyc - last_poll), 32'(TbGap + 1));
        last_busy = m_rdata[0];
        last_poll = cyc;
        if (m_rdata[0]) n_busy_polls++;
      end
      chk("frame_done", 32'(frame_done), 32'(e_done));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("cur_slot", 32'(cur_slot), 32'(exp_slot));
      chk("err_timeout", 32'(err_timeout), 32'(e_to));
      if (e_to) begin
        chk("timeout_sel_low", 32'(m_sel), 32'h0);
        n_timeouts++;
      end
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (e_done) exp_slot = ~exp_slot;
      run    = (m_sel && !m_ack) ? run + 1 : 0;
      p_hold = m_sel && !m_ack;
      p_wr   = m_wr;
      p_addr = m_addr;
      p_wdata = m_wdata;
    end
  end

  task automatic put_word(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    res_valid = 1'b1;
    res_data  = d;
    res_last  = l;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (res_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    res_last  = 1'b0;
    chk("handshake", 32'(ok), 32'h1);
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) put_word(base + 32'(i), i == n - 1);
  endtask

  task automatic wait_done();
    int target = n_done + 1;
    bit got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      #1;
      if (n_done >= target) got = 1'b1;
    end
    chk("done_wait", 32'(got), 32'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    push_frame(n, base);
    send_words(n, base);
    wait_done();
  endtask

  task automatic vm_clear(input logic s);
    vm_clr_slot = s;
    vm_clr      = 1'b1;
    @(posedge clk);
    #1;
    vm_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({res_ready, m_sel, m_wr, busy, cur_slot, frame_done, frame_err, err_timeout}),
        32'h0);
    chk({name, "_addr"}, m_addr, 32'h0);
    chk({name, "_wdata"}, m_wdata, 32'h0);
  endtask

  initial begin
    int wr_before;
    bit got;
    rst       = 1'b1;
    res_valid = 1'b0;
    res_data  = 32'h0;
    res_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: empty mailbox, slot 0.
    send_frame(16, 32'hA0);
    chk("t1_cur_slot", 32'(cur_slot), 32'h1);
    chk("t1_flag0", mb_flag[0], 32'h1);
    chk("t1_word5", mb_data[0][5], 32'hA5);

    // 2: slot 1, slow slave.
    lat = 2;
    send_frame(16, 32'hB0);
    lat = 0;
    chk("t2_cur_slot", 32'(cur_slot), 32'h0);
    chk("t2_flag1", mb_flag[1], 32'h1);
    chk("t2_word15", mb_data[1][15], 32'hBF);
    chk("t2_err_count", 32'(n_err), 32'h0);

    // 3: slot 0 still occupied; only polls until the VM acknowledges.
    push_frame(16, 32'hC0);
    wr_before = n_writes;
    res_valid = 1'b1;
    res_data  = 32'hC0;
    repeat (40) @(posedge clk);
    #1;
    chk("t3_no_writes", 32'(n_writes - wr_before), 32'h0);
    chk("t3_busy_polls_ge6", 32'(n_busy_polls >= 6), 32'h1);
    vm_clear(1'b0);
    send_words(16, 32'hC0);
    wait_done();
    chk("t3_word0", mb_data[0][0], 32'hC0);
    chk("t3_cur_slot", 32'(cur_slot), 32'h1);

    // 4: short frame into slot 1, padded with zeros.
    vm_clear(1'b1);
    send_frame(3, 32'hD0);
    chk("t4_word2", mb_data[1][2], 32'hD2);
    chk("t4_word3_pad", mb_data[1][3], 32'h0);
    chk("t4_word15_pad", mb_data[1][15], 32'h0);
    chk("t4_err_count", 32'(n_err), 32'h1);
    chk("t4_cur_slot", 32'(cur_slot), 32'h0);

    // 5: long frame into slot 0, tail drained; then a clean frame into slot 1.
    vm_clear(1'b0);
    send_frame(18, 32'hE0);
    chk("t5_word15", mb_data[0][15], 32'hEF);
    chk("t5_err_count", 32'(n_err), 32'h2);
    chk("t5_done_count", 32'(n_done), 32'h5);
    vm_clear(1'b1);
    send_frame(16, 32'h30);
    chk("t5b_err_count", 32'(n_err), 32'h2);
    chk("t5b_word3", mb_data[1][3], 32'h33);

    // 6a: slave never acks the data write.
    vm_clear(1'b0);
    hang_wr = 1'b1;
    put_word(32'h60, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      #1;
      if (n_timeouts == 1) got = 1'b1;
    end
    chk("t6_timeout_seen", 32'(got), 32'h1);
    @(posedge clk);
    #1;
    hang_wr = 1'b0;
    chk("t6_cur_slot", 32'(cur_slot), 32'h0);
    chk("t6_idle", 32'({busy, m_sel}), 32'h0);
    chk("t6_no_data", mb_data[0][0], 32'hE0);
    chk("t6_no_commit", mb_flag[0], 32'h0);

    // 6b: reset in the middle of DATA.
    push_frame(16, 32'h70);
    send_words(5, 32'h70);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_reset_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk("t6_partial_word4", mb_data[0][4], 32'h74);
    chk("t6_untouched_word5", mb_data[0][5], 32'hE5);
    chk("t6_reset_no_commit", mb_flag[0], 32'h0);

    // Recovery frame after reset.
    @(posedge clk);
    #1;
    send_frame(16, 32'h50);
    chk("rec_word0", mb_data[0][0], 32'h50);
    chk("rec_flag0", mb_flag[0], 32'h1);
    chk("rec_cur_slot", 32'(cur_slot), 32'h1);
    chk("rec_done_count", 32'(n_done), 32'h7);
    chk("rec_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boreal_ai_mailbox_writer.md
Name: boreal_ai_mailbox_writer

Overview:
AI-side initiator for the AI mailbox MMIO slave. It accepts 16-word inference result frames from the accelerator on a valid/ready stream and writes them into the mailbox over the mailbox MMIO bus. Slots 0 and 1 are used alternately. Before writing a slot it polls that slot's valid flag, so a frame the Decision-VM has not yet acknowledged is never overwritten. It sits between the accelerator output and the mailbox slave port.

Parameters:
BASE_ADDR, 32'h0000_0000, mailbox base address; only the offsets below are added to it.
POLL_GAP, 4, idle cycles between valid-flag polls while the target slot is still occupied (1..255).
ACK_TIMEOUT, 255, maximum cycles m_sel is held without m_ack before the transaction is aborted (1..65535).

Ports:
clk  in  1  single clock, all logic on posedge.
rst  in  1  asynchronous active-high reset.
res_valid  in  1  accelerator result word valid.
res_ready  out  1  writer accepts word.
res_data  in  32  result word.
res_last  in  1  last word of frame.
m_sel  out  1  MMIO select.
m_wr  out  1  1=write, 0=read.
m_addr  out  32  MMIO byte address.
m_wdata  out  32  MMIO write data.
m_rdata  in  32  MMIO read data.
m_ack  in  1  MMIO acknowledge; may be combinational in m_sel.
busy  out  1  high whenever FSM not in IDLE.
cur_slot  out  1  slot the next or current frame targets.
frame_done  out  1  one-cycle pulse on commit accepted.
frame_err  out  1  one-cycle pulse at commit if frame length is not 16.
err_timeout  out  1  one-cycle pulse on ACK_TIMEOUT abort.

Behaviour:
- Address map, with S = cur_slot:
  - Valid flag: BASE_ADDR+4*S.
  - Data word i: BASE_ADDR+0x40+0x40*S+4*i, i = 0..15.
- Reset: all outputs 0, FSM in IDLE, cur_slot=0, word index 0, counters 0. A reset mid-frame abandons the frame and makes no commit write.
- Bus rule:
  - m_sel, m_wr, m_addr and m_wdata are registered and held stable until m_ack is sampled high.
  - m_sel drops in the cycle after ack.
  - The next transaction may start in that cycle.
  - A zero-latency slave gives 1 cycle per access.
- States:
  - IDLE: res_ready=0. If res_valid=1, go to POLL. No word is consumed.
  - POLL: read the valid flag (m_wr=0). On ack, if m_rdata[0]=1, go to WAIT. If 0, go to DATA with word index 0.
  - WAIT: count POLL_GAP cycles, then go to POLL.
  - DATA:
    - res_ready=1 only when no write is outstanding.
    - On handshake, capture res_data and issue a write to data word idx in the next cycle.
    - On ack, increment idx. Throughput is 1 word per 2 cycles with a zero-latency slave.
    - res_last on idx<15: set err flag, go to PAD.
    - idx 15 written without res_last: set err flag, go to DRAIN.
    - idx 15 written with res_last: go to COMMIT.
  - PAD: res_ready=0. Write 32'h0 to the remaining idx..15, then go to COMMIT.
  - DRAIN: res_ready=1. Discard words up to and including res_last, then go to COMMIT.
  - COMMIT: write 32'h1 to the valid flag. On ack:
    - pulse frame_done;
    - pulse frame_err if err flag is set, then clear err flag;
    - toggle cur_slot;
    - go to IDLE.
- Timeout:
  - A counter runs while m_sel=1 and m_ack=0.
  - On reaching ACK_TIMEOUT: drop m_sel, pulse err_timeout, clear err flag, go to IDLE.
  - cur_slot is not toggled and no commit write is made.
  - Remaining stream words of the frame are not drained; the next res_valid restarts at POLL.
- Width/wrap:
  - idx is 4 bits and never wraps past 15.
  - The POLL_GAP counter is 8 bits; the timeout counter is 16 bits.
- Simultaneous events: res_valid arriving during COMMIT is ignored until IDLE. There is no concurrency with VM acks; slot ownership is resolved purely by polling.

Test Plan:
1. Mailbox empty, frame 0xA0..0xAF, last on word 15 -> writes to 0x40..0x7C, then write 1 to 0x00. frame_done=1 for one cycle, cur_slot=1, mailbox vm_slot0_valid=1, vm_rd_data idx 5 = 0xA5.
2. Second frame 0xB0..0xBF -> writes to 0x80..0xBC, commit to 0x04, cur_slot=0, frame_err=0.
3. Third frame while slot0 valid -> only reads of 0x00, every POLL_GAP+1=5 cycles, no data writes. After vm_slot0_ack, the next poll reads 0 and data goes to 0x40.
4. Short frame of 3 words (last on word 2) -> words 3..15 written 0x0, commit, frame_done and frame_err pulse in the same cycle.
5. Long frame of 18 words -> 16 words written, 2 words accepted and discarded, single commit, frame_err=1 once, next frame starts clean.
6. Slave holds m_ack=0 in DATA -> err_timeout pulse exactly ACK_TIMEOUT cycles after m_sel rises, m_sel=0, no commit, cur_slot unchanged. Separately, rst asserted mid-DATA -> all outputs 0 immediately.
